noc_perf_monitor: RTL

Synthesizable per-PE performance monitor for the NoC mesh. It accumulates, per channel, PE stall cycles, router conflict cycles and the cycle at which the PE first raised done. It also keeps a global cycle count from start to layer completion. One instance sits beside the mesh, one channel per PE/router pair with index x + MESH_SIZE·y. Counters are read back over a registered, one-cycle-latency read port, so the same statistics are available on silicon and in regression.

---
 rtl/noc_perf_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/noc_perf_monitor.sv
// Per-channel NoC performance monitor: stall, conflict and done-cycle counters
// plus a global cycle count, read back through a registered one-cycle port.
module noc_perf_monitor #(
  parameter  int N_CH      = 16,
  parameter  int CNT_W     = 32,
  parameter  int AUTO_STOP = 1,
  localparam int IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             layer_finished,
  input  logic [N_CH-1:0]  pe_stall,
  input  logic [N_CH-1:0]  router_conflict,
  input  logic [N_CH-1:0]  pe_done,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_err,
  output logic             running,
  output logic             finished,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W:0]   NCH_L   = (IDX_W+1)'(N_CH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_stall [N_CH];
  logic [CNT_W-1:0] r_conf  [N_CH];
  logic [CNT_W-1:0] r_dcyc  [N_CH];
  logic [N_CH-1:0]  r_dcap;
  logic             r_ovf, r_running, r_finished;
  logic             r_rd_valid, r_rd_err;
  logic [CNT_W-1:0] r_rd_data;

  logic [CNT_W-1:0] w_cycle_nxt, w_cap_cnt, w_rd_data;
  logic [N_CH-1:0]  w_cap_nxt;
  logic             w_to_hold, w_ovf_hit, w_idx_ok, w_rd_err;
  logic [IDX_W-1:0] w_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) return v + CNT_W'(1);
    else                      return v;
  endfunction

  // Saturating increments, done capture and overflow detection for a RUN cycle
  always_comb begin
    w_cycle_nxt = sat_inc(r_cycle, 1'b1);
    w_cap_nxt   = r_dcap | pe_done;
    w_to_hold   = layer_finished || ((AUTO_STOP != 0) && (&w_cap_nxt));
    w_ovf_hit   = (r_cycle == CNT_MAX);
    w_cap_cnt   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pe_stall[i] && (r_stall[i] == CNT_MAX))       w_ovf_hit = 1'b1;
      if (router_conflict[i] && (r_conf[i] == CNT_MAX)) w_ovf_hit = 1'b1;
      w_cap_cnt = w_cap_cnt + CNT_W'(r_dcap[i]);
    end
  end

  // Next-state logic; clear overrides start and layer_finished
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start)     w_state_nxt = S_RUN;
        S_RUN:   if (w_to_hold) w_state_nxt = S_HOLD;
        S_HOLD:  if (start)     w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register with registered state decodes
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_finished <= (w_state_nxt == S_HOLD);
    end
  end

  // Counter bank; start only re-arms from IDLE/HOLD and leaves overflow sticky
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cycle <= '0;
      r_dcap  <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_stall[i] <= '0;
        r_conf[i]  <= '0;
        r_dcyc[i]  <= '0;
      end
    end else if (clear || ((r_state != S_RUN) && start)) begin
      r_cycle <= '0;
      r_dcap  <= '0;
      if (clear) r_ovf <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_stall[i] <= '0;
        r_conf[i]  <= '0;
        r_dcyc[i]  <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_cycle <= w_cycle_nxt;
      r_dcap  <= w_to_hold ? {N_CH{1'b1}} : w_cap_nxt;
      if (w_ovf_hit) r_ovf <= 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        r_stall[i] <= sat_inc(r_stall[i], pe_stall[i]);
        r_conf[i]  <= sat_inc(r_conf[i], router_conflict[i]);
        if (!r_dcap[i] && (pe_done[i] || w_to_hold)) r_dcyc[i] <= w_cycle_nxt;
      end
    end
  end

  // Read mux over pre-update counter values
  always_comb begin
    w_idx_ok  = ({1'b0, rd_idx} < NCH_L);
    w_idx     = w_idx_ok ? rd_idx : '0;
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (rd_sel)
      2'd0: if (w_idx_ok) w_rd_data = r_stall[w_idx]; else w_rd_err = 1'b1;
      2'd1: if (w_idx_ok) w_rd_data = r_conf[w_idx];  else w_rd_err = 1'b1;
      2'd2: if (w_idx_ok) w_rd_data = r_dcap[w_idx] ? r_dcyc[w_idx] : '0; else w_rd_err = 1'b1;
      2'd3: begin
        if (rd_idx == IDX_W'(0))      w_rd_data = r_cycle;
        else if (rd_idx == IDX_W'(1)) w_rd_data = w_cap_cnt;
        else                          w_rd_err  = 1'b1;
      end
      default: w_rd_err = 1'b1;
    endcase
  end

  // Registered read port
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_data  <= rd_en ? w_rd_data : '0;
      r_rd_err   <= rd_en ? w_rd_err : 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;
  assign running  = r_running;
  assign finished = r_finished;
  assign overflow = r_ovf;

endmodule
